// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with a one-word holding register.
//
// The serial line is synchronised, oversampled 16x per bit by a tick divider,
// and each bit is resolved by a 3-sample majority vote around mid-bit.
// Received words are held in an output register with valid/ready handshake.
//
// Configuration macro: UART_RX_PARITY_EN
//   defined   - one parity bit follows the data bits; PARITY_ODD selects
//               even (0) or odd (1) parity and a mismatch sets parity_err.
//   undefined - no parity bit is expected and parity_err is tied to 0.
//
// Parameters: CLK_HZ, BAUD, DATA_BITS (5..9), STOP_BITS (1..2), PARITY_ODD.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   RxD         asynchronous serial input, idles high
//   rx_data     received word (LSB first on the line)
//   rx_valid    rx_data and sideband flags are valid
//   rx_ready    consumer accepts the held word
//   frame_err   held word had a stop bit sampled low
//   parity_err  held word failed its parity check
//   break_det   held word is a break (all data 0, stop bit low)
//   overrun     sticky: a frame was dropped because the holder was full
//   clr_err     synchronous clear of overrun
//   busy        receiver is not idle
`timescale 1ns/1ps

module uart_rx_param #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun,
  input  logic                 clr_err,
  output logic                 busy
);

  // Rounded divide: ticks arrive 16 times per bit.
  localparam int unsigned DIV   = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_rx_param: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_e;

  // Line synchroniser and edge detector.
  logic       rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [1:0] arm_q;
  logic       start_edge;

  // Receiver state.
  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [1:0]             ones_q, ones_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   ferr_acc_q, ferr_acc_d;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic                   par_acc_q, par_acc_d;
  logic                   perr_acc_q, perr_acc_d;
  logic                   perr_q, perr_d;
`endif

  // Holding register.
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;
  logic                   ovr_q, ovr_d;

  logic       tick;
  logic [1:0] vote_sum;
  logic       bit_val;
  logic       frame_now;
  logic       complete, comp_brk;
  logic       load, drop;

  // The sync flops reset to 1 (idle line); edges are only honoured once arm_q
  // shows that rxd_prev_q holds a real line sample, so a line already low at
  // reset release is never mistaken for a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      arm_q      <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      rxd_meta_q <= RxD;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      arm_q      <= (arm_q == 2'd3) ? 2'd3 : arm_q + 2'd1;
    end
  end

  assign start_edge = (arm_q == 2'd3) && rxd_prev_q && !rxd_sync_q;
  assign tick       = (div_q == DIV_LAST);

  // Majority of samples at ticks 7, 8 and the current tick 9.
  assign vote_sum  = ones_q + {1'b0, rxd_sync_q};
  assign bit_val   = vote_sum[1];
  assign frame_now = ferr_acc_q | ~bit_val;

  // tick_cnt_q holds the number of ticks already seen in the current bit, so
  // tick_cnt_q == k-1 while the k-th tick is being presented.
  always_comb begin : fsm_comb
    // NOTE: every combinational output gets a default first; without it a
    // branch that skips an assignment would infer a latch.
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    ones_d     = ones_q;
    shift_d    = shift_q;
    ferr_acc_d = ferr_acc_q;
    complete   = 1'b0;
    comp_brk   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_d  = par_acc_q;
    perr_acc_d = perr_acc_q;
`endif
    div_d = (state_q == S_IDLE || tick) ? '0 : div_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_START;
          tick_cnt_d = 4'd0;
          bit_idx_d  = 4'd0;
          ones_d     = 2'd0;
          ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_acc_d  = 1'b0;
          perr_acc_d = 1'b0;
`endif
        end
      end

      S_START: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7 && rxd_sync_q) begin
            state_d = S_IDLE;            // false start
          end else if (tick_cnt_q == 4'd15) begin
            state_d = S_DATA;            // counter wraps to 0 for bit 0
          end
        end
      end

      S_DATA, S_PARITY, S_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd6 || tick_cnt_q == 4'd7) begin
            ones_d = vote_sum;
          end else if (tick_cnt_q == 4'd8) begin
            ones_d = 2'd0;
            if (state_q == S_DATA) begin
              shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
              par_acc_d = par_acc_q ^ bit_val;
`endif
            end
`ifdef UART_RX_PARITY_EN
            if (state_q == S_PARITY) begin
              perr_acc_d = par_acc_q ^ bit_val ^ PAR_ODD;
            end
`endif
            if (state_q == S_STOP) begin
              ferr_acc_d = frame_now;
              if (bit_idx_q == LAST_STOP) begin
                complete = 1'b1;
                comp_brk = frame_now && (shift_q == '0);
                state_d  = comp_brk ? S_BRKWAIT : S_IDLE;
              end
            end
          end else if (tick_cnt_q == 4'd15) begin
            bit_idx_d = bit_idx_q + 4'd1;
            if (state_q == S_DATA && bit_idx_q == LAST_DATA) begin
              bit_idx_d = 4'd0;
`ifdef UART_RX_PARITY_EN
              state_d   = S_PARITY;
`else
              state_d   = S_STOP;
`endif
            end else if (state_q == S_PARITY) begin
              bit_idx_d = 4'd0;
              state_d   = S_STOP;
            end
          end
        end
      end

      S_BRKWAIT: begin
        if (rxd_sync_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A completing frame loads when the holder is empty or being drained in
  // the same cycle; otherwise it is dropped and overrun latches.
  always_comb begin : hold_comb
    load    = complete && (!valid_q || rx_ready);
    drop    = complete && valid_q && !rx_ready;
    data_d  = load ? shift_q   : data_q;
    ferr_d  = load ? frame_now : ferr_q;
    brk_d   = load ? comp_brk  : brk_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = load ? perr_acc_q : perr_q;
`endif
    valid_d = load ? 1'b1 : ((valid_q && rx_ready) ? 1'b0 : valid_q);
    ovr_d   = drop ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= 4'd0;
      ones_q     <= 2'd0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= 1'b0;
      perr_acc_q <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      ones_q     <= ones_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_acc_q  <= par_acc_d;
      perr_acc_q <= perr_acc_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign break_det = brk_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
